// File: rtl/mem_access_pkg.sv
// Shared definitions for the MiniMIPS load/store controller: FSM encoding,
// access-size codes, read-latency limits and alignment helper.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 8;
    localparam int LAT_W      = 3;

    // Size code 11 behaves as a word everywhere, so bit 1 alone marks a word.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_HALF && lo[0]) ||
               (size == SZ_WORD && lo != 2'b00) ||
               (size == 2'b11);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane logic: extracts and extends load data, and merges
// sub-word store data into the word read back from memory.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rd_word[{lane, 3'b000} +: 8];
        half_v     = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data  = rd_word;
        merge_word = rd_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
                merge_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_v[15]}}, half_v};
                if (lane[1]) merge_word[31:16] = wdata[15:0];
                else         merge_word[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = rd_word;
                merge_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU request/response handshakes and the
// DataMemory port. Optional alignment checking: MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the sender holds its payload stable until that edge.

    state_t             state, state_d;
    logic [LAT_W-1:0]   lat_cnt;
    logic               lat_done;
    logic               r_store;
    logic [1:0]         r_size;
    logic               r_signed;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        wr_word;
    logic [31:0]        rsp_data;
    logic               rsp_err;
    logic               req_err;
    logic [31:0]        load_data;
    logic [31:0]        merge_word;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign req_err = misaligned(req_size, req_addr[1:0]);
`else
    assign req_err = 1'b0;
`endif

    assign lat_done       = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign mem_address    = {2'b00, r_addr[ADDR_W-1:2]};
    assign mem_write_data = wr_word;
    assign resp_data      = rsp_data;
    assign resp_err       = rsp_err;
    assign dbg_state      = state;

    mem_lane_unit u_lane (
        .size       (r_size),
        .sign_ext   (r_signed),
        .lane       (r_addr[1:0]),
        .rd_word    (mem_read_data),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    always_comb begin
        state_d    = state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated so ready reads low for the whole reset assertion.
                req_ready = reset_n;
                if (req_valid) begin
                    if (req_err)                              state_d = RESP;
                    else if (req_store && is_word(req_size))  state_d = WR;
                    else                                      state_d = RD;
                end
            end
            RD: begin
                MemRead = 1'b1;
                if (lat_done) state_d = r_store ? WR : RESP;
            end
            WR: begin
                MemWrite = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            r_store  <= 1'b0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            wr_word  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        wr_word  <= req_wdata;
                        lat_cnt  <= '0;
                        rsp_data <= '0;
                        rsp_err  <= req_err;
                    end
                end
                RD: begin
                    if (lat_done) begin
                        if (r_store) wr_word  <= merge_word;
                        else         rsp_data <= load_data;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at READ_LATENCY=1, one at 3,
// each with a small behavioural word memory.
module tb_mem_access_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Instance A: READ_LATENCY = 1
    logic        req_valid_a = 0, req_store_a = 0, req_signed_a = 0, resp_ready_a = 0;
    logic [1:0]  req_size_a = 0;
    logic [31:0] req_addr_a = 0, req_wdata_a = 0;
    logic        req_ready_a, resp_valid_a, resp_err_a, mw_a, mr_a;
    logic [31:0] resp_data_a, maddr_a, mwd_a, mrd_a;
    logic [1:0]  state_a;

    // Instance B: READ_LATENCY = 3
    logic        req_valid_b = 0, req_store_b = 0, req_signed_b = 0, resp_ready_b = 0;
    logic [1:0]  req_size_b = 0;
    logic [31:0] req_addr_b = 0, req_wdata_b = 0;
    logic        req_ready_b, resp_valid_b, resp_err_b, mw_b, mr_b;
    logic [31:0] resp_data_b, maddr_b, mwd_b, mrd_b;
    logic [1:0]  state_b;

    mem_access_ctrl #(.READ_LATENCY(1), .ADDR_W(32)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_store(req_store_a),
        .req_size(req_size_a), .req_signed(req_signed_a), .req_addr(req_addr_a),
        .req_wdata(req_wdata_a), .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_data(resp_data_a), .resp_err(resp_err_a), .MemWrite(mw_a), .MemRead(mr_a),
        .mem_address(maddr_a), .mem_write_data(mwd_a), .mem_read_data(mrd_a),
        .dbg_state(state_a)
    );

    mem_access_ctrl #(.READ_LATENCY(3), .ADDR_W(32)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_store(req_store_b),
        .req_size(req_size_b), .req_signed(req_signed_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_data(resp_data_b), .resp_err(resp_err_b), .MemWrite(mw_b), .MemRead(mr_b),
        .mem_address(maddr_b), .mem_write_data(mwd_b), .mem_read_data(mrd_b),
        .dbg_state(state_b)
    );

    // Memory models
    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    int rd_cnt_a = 0, wr_cnt_a = 0, rd_cnt_b = 0, wr_cnt_b = 0, both_cnt = 0;
    logic [31:0] last_waddr_a = 0, last_wdata_a = 0;

    assign mrd_a = mem_a[maddr_a[3:0]];
    assign mrd_b = mem_b[maddr_b[3:0]];

    always @(posedge clock) begin
        if (mw_a) begin
            mem_a[maddr_a[3:0]] <= mwd_a;
            wr_cnt_a     <= wr_cnt_a + 1;
            last_waddr_a <= maddr_a;
            last_wdata_a <= mwd_a;
        end
        if (mr_a) rd_cnt_a <= rd_cnt_a + 1;
        if (mw_b) begin
            mem_b[maddr_b[3:0]] <= mwd_b;
            wr_cnt_b <= wr_cnt_b + 1;
        end
        if (mr_b) rd_cnt_b <= rd_cnt_b + 1;
    end

    always @(negedge clock) begin
        if ((mr_a && mw_a) || (mr_b && mw_b)) both_cnt = both_cnt + 1;
    end

    // Full request/response transaction on instance A.
    task automatic txn_a(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err,
                         output int nrd, output int nwr);
        int rd0, wr0;
        rd0 = rd_cnt_a;
        wr0 = wr_cnt_a;
        @(negedge clock);
        req_store_a = st; req_size_a = sz; req_signed_a = sg;
        req_addr_a = addr; req_wdata_a = wd; req_valid_a = 1'b1;
        @(posedge clock);
        #1 req_valid_a = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!resp_valid_a && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!resp_valid_a) lat = -1;
        data = resp_data_a;
        err  = resp_err_a;
        resp_ready_a = 1'b1;
        @(posedge clock);
        #1 resp_ready_a = 1'b0;
        nrd = rd_cnt_a - rd0;
        nwr = wr_cnt_a - wr0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({req_ready_a, resp_valid_a, resp_err_a, mw_a, mr_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {req_ready_a, resp_valid_a, resp_err_a, mw_a, mr_a});
        end
        checks++;
        if ({resp_data_a, maddr_a, mwd_a} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected all 0", resp_data_a, maddr_a, mwd_a);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (req_ready_a !== 1'b1 || state_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b state=%0d expected ready=1 state=0",
                     req_ready_a, state_a);
        end
    endtask

    task automatic test_word_store();
        int lat, nrd, nwr;
        logic [31:0] data;
        logic err;
        txn_a(1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFF_FFF1, lat, data, err, nrd, nwr);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        checks++;
        if (nwr !== 1 || nrd !== 0) begin
            errors++; $display("FAIL sw_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", nwr, nrd);
        end
        checks++;
        if (last_waddr_a !== 32'h1 || last_wdata_a !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL sw_write: got addr=%h data=%h expected addr=1 data=fffffff1",
                     last_waddr_a, last_wdata_a);
        end
        checks++;
        if (err !== 1'b0 || data !== 32'h0) begin
            errors++; $display("FAIL sw_resp: got err=%b data=%h expected err=0 data=0", err, data);
        end
    endtask

    task automatic test_loads();
        int lat, nrd, nwr;
        logic [31:0] data;
        logic err;
        logic [31:0] addrs [5] = '{32'h5, 32'h5, 32'h6, 32'h4, 32'h7};
        logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        sgns  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234,
                                   32'hFFFF_80F1, 32'h0000_0012};
        txn_a(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_80F1, lat, data, err, nrd, nwr);
        for (int i = 0; i < 5; i++) begin
            txn_a(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, lat, data, err, nrd, nwr);
            checks++;
            if (data !== exps[i]) begin
                errors++; $display("FAIL load_data[%0d]: got %h expected %h", i, data, exps[i]);
            end
            checks++;
            if (lat !== 2 || nrd !== 1 || nwr !== 0 || err !== 1'b0) begin
                errors++;
                $display("FAIL load_timing[%0d]: got lat=%0d rd=%0d wr=%0d err=%b expected 2 1 0 0",
                         i, lat, nrd, nwr, err);
            end
        end
    endtask

    task automatic test_rmw();
        int lat, nrd, nwr;
        logic [31:0] data;
        logic err;
        txn_a(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678, lat, data, err, nrd, nwr);
        txn_a(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_ABCD, lat, data, err, nrd, nwr);
        checks++;
        if (lat !== 3 || nrd !== 1 || nwr !== 1) begin
            errors++;
            $display("FAIL sh_timing: got lat=%0d rd=%0d wr=%0d expected 3 1 1", lat, nrd, nwr);
        end
        checks++;
        if (last_wdata_a !== 32'hABCD_5678) begin
            errors++; $display("FAIL sh_merge: got %h expected abcd5678", last_wdata_a);
        end
        txn_a(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, data, err, nrd, nwr);
        checks++;
        if (data !== 32'hABCD_5678) begin
            errors++; $display("FAIL sh_readback: got %h expected abcd5678", data);
        end
        txn_a(1'b1, 2'b00, 1'b0, 32'h4, 32'h0000_00EE, lat, data, err, nrd, nwr);
        checks++;
        if (lat !== 3 || last_wdata_a !== 32'hABCD_56EE) begin
            errors++; $display("FAIL sb_lane0: got lat=%0d data=%h expected 3 abcd56ee", lat, last_wdata_a);
        end
        txn_a(1'b1, 2'b00, 1'b0, 32'h7, 32'hFFFF_FF99, lat, data, err, nrd, nwr);
        txn_a(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, data, err, nrd, nwr);
        checks++;
        if (data !== 32'h99CD_56EE) begin
            errors++; $display("FAIL sb_lane3: got %h expected 99cd56ee", data);
        end
    endtask

    task automatic test_read_latency();
        int n, lat, rd0;
        @(negedge clock);
        req_store_b = 1'b1; req_size_b = 2'b10; req_addr_b = 32'h4;
        req_wdata_b = 32'hCAFE_F00D; req_valid_b = 1'b1;
        @(posedge clock);
        #1 req_valid_b = 1'b0;
        n = 0;
        while (!resp_valid_b && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (resp_valid_b !== 1'b1) begin
            errors++; $display("FAIL rl3_sw_timeout: got resp_valid=%b expected 1", resp_valid_b);
        end
        resp_ready_b = 1'b1;
        @(posedge clock);
        #1 resp_ready_b = 1'b0;

        rd0 = rd_cnt_b;
        @(negedge clock);
        req_store_b = 1'b0; req_valid_b = 1'b1;
        @(posedge clock);
        #1 req_valid_b = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!resp_valid_b && lat < 20) begin @(negedge clock); lat++; end
        checks++;
        if (lat !== 4 || rd_cnt_b - rd0 !== 3) begin
            errors++;
            $display("FAIL rl3_timing: got lat=%0d reads=%0d expected 4 3", lat, rd_cnt_b - rd0);
        end
        checks++;
        if (resp_data_b !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rl3_data: got %h expected cafef00d", resp_data_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({resp_valid_b, req_ready_b, mr_b, mw_b} !== 4'b1000 || resp_data_b !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL rl3_hold[%0d]: got vrdw=%b data=%h expected 1000 cafef00d",
                         i, {resp_valid_b, req_ready_b, mr_b, mw_b}, resp_data_b);
            end
        end
        resp_ready_b = 1'b1;
        @(posedge clock);
        #1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (resp_valid_b !== 1'b0 || req_ready_b !== 1'b1 || state_b !== 2'd0) begin
            errors++;
            $display("FAIL idle_resp_ready: got valid=%b ready=%b state=%0d expected 0 1 0",
                     resp_valid_b, req_ready_b, state_b);
        end
        resp_ready_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, nrd, nwr, wr0;
        logic [31:0] data;
        logic err;
        txn_a(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, lat, data, err, nrd, nwr);
        wr0 = wr_cnt_a;
        @(negedge clock);
        req_store_a = 1'b1; req_size_a = 2'b00; req_addr_a = 32'h4;
        req_wdata_a = 32'h0000_0055; req_valid_a = 1'b1;
        @(posedge clock);
        #1 req_valid_a = 1'b0;
        checks++;
        if (mr_a !== 1'b1) begin errors++; $display("FAIL rst_mid_rd: got MemRead=%b expected 1", mr_a); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({mr_a, mw_a, req_ready_a} !== 3'b000 || state_a !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_drop: got rd/wr/ready=%b state=%0d expected 000 0",
                     {mr_a, mw_a, req_ready_a}, state_a);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (req_ready_a !== 1'b1 || wr_cnt_a !== wr0) begin
            errors++;
            $display("FAIL rst_mid_after: got ready=%b writes=%0d expected 1 0", req_ready_a, wr_cnt_a - wr0);
        end
        txn_a(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, data, err, nrd, nwr);
        checks++;
        if (data !== 32'h1122_3344) begin
            errors++; $display("FAIL rst_mid_word: got %h expected 11223344", data);
        end
    endtask

    task automatic test_align();
        int lat, nrd, nwr;
        logic [31:0] data;
        logic err;
        txn_a(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, data, err, nrd, nwr);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        checks++;
        if (lat !== 1 || err !== 1'b1 || data !== 32'h0 || nrd !== 0 || nwr !== 0) begin
            errors++;
            $display("FAIL align_err: got lat=%0d err=%b data=%h rd=%0d wr=%0d expected 1 1 0 0 0",
                     lat, err, data, nrd, nwr);
        end
`else
        checks++;
        if (lat !== 2 || err !== 1'b0 || data !== 32'h1122_3344 || nrd !== 1 || nwr !== 0) begin
            errors++;
            $display("FAIL align_ignore: got lat=%0d err=%b data=%h rd=%0d wr=%0d expected 2 0 11223344 1 0",
                     lat, err, data, nrd, nwr);
        end
`endif
    endtask

    task automatic test_strobe_exclusive();
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_rmw();
        test_read_latency();
        test_reset_mid();
        test_align();
        test_strobe_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side load/store controller for the MiniMIPS data path; drives the DataMemory port (MemWrite, MemRead, address, write_data, read_data).
- Accepts one CPU load/store request at a time over a valid/ready handshake and returns a response over a valid/ready handshake.
- Handles byte/halfword/word accesses: sign/zero extension on loads, read-modify-write on sub-word stores.

Parameters:
- READ_LATENCY, 1, cycles MemRead and address are held before read_data is sampled (1 = sampled at the edge ending the first MemRead cycle); legal 1..8.
- ADDR_W, 32, byte-address width on the CPU side and address width on the memory side.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  CPU accepts the response.
- resp_data  out  32  load result (0 for stores).
- resp_err  out  1  access error (see Optional Feature).
- MemWrite  out  1  memory write strobe.
- MemRead  out  1  memory read strobe.
- mem_address  out  ADDR_W  word index = req_addr >> 2.
- mem_write_data  out  32  full write word.
- mem_read_data  in  32  memory read word.

Behaviour:
- Reset (async, while reset_n=0):
  - State goes to IDLE.
  - req_ready, resp_valid, resp_err, MemWrite and MemRead are all 0.
  - resp_data, mem_address and mem_write_data are 0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register store, size, signed, addr and wdata.
  - Next state: word store → WR; any load or sub-word store → RD.
- RD:
  - MemRead=1 and mem_address stable.
  - lat_cnt counts 0..READ_LATENCY-1; mem_read_data is sampled at the edge where lat_cnt = READ_LATENCY-1.
  - After sampling: a load goes to RESP with the extended result; a sub-word store goes to WR with the merged word.
- WR:
  - MemWrite=1 for exactly one cycle, with mem_address and mem_write_data stable.
  - Next state: RESP.
- RESP:
  - resp_valid=1 and resp_data/resp_err held stable.
  - Leave to IDLE on resp_ready; no new request is accepted in the same cycle.
- req_ready=0 in every state except IDLE. MemRead and MemWrite are never high together.
- Latency, accept edge to resp_valid, with READ_LATENCY=1:
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - READ_LATENCY adds (READ_LATENCY-1) cycles to any access that passes through RD.
- Byte lanes are little-endian; lane k = bits 8k+7:8k.
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits 15:0 or 31:16).
- Loads: extract the lane, then sign- or zero-extend to 32 bits. The word load result is the read word as-is.
- Sub-word stores: replace only the addressed lane of the read word with the low bits of wdata; all other lanes are preserved.
- Size 11 is treated as word.
- Reset mid-operation: strobes drop immediately and the transaction is discarded. An RMW interrupted in RD performs no write.
- resp_ready asserted while resp_valid=0 is ignored.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined:
  - An access is an error when it is a half with addr[0]=1, a word with addr[1:0]≠00, or size=11.
  - The error goes IDLE→RESP directly: resp_err=1, resp_data=0, no MemRead or MemWrite.
  - Latency is 1 cycle.
- Undefined:
  - resp_err is tied to 0.
  - Low address bits below the access size are ignored: a word access uses addr[31:2], a half uses addr[1] only.

Decomposition:
- Package mem_access_pkg holds:
  - the state encoding (IDLE/RD/WR/RESP);
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - the READ_LATENCY legal-range constant.
- One sub-module, mem_lane_unit: combinational lane extract/extend for loads and lane merge for stores. The FSM and counter stay in the top.

Test Plan:
- SW addr 0x4, wdata 0xFFFFFFF1 → one MemWrite cycle with mem_address=1 and mem_write_data=0xFFFFFFF1; resp_valid 2 cycles after accept; resp_err=0.
- Memory word 1 = 0x123480F1, LB addr 0x5 signed → resp_data 0xFFFFFF80; LBU → 0x00000080; LHU addr 0x6 → 0x00001234.
- Memory word 1 = 0x12345678, SH addr 0x6, wdata 0x0000ABCD → RD cycle then WR with 0xABCD5678; a subsequent LW addr 0x4 returns 0xABCD5678.
- READ_LATENCY=3, LW addr 0x4 → MemRead high 3 cycles; resp_valid 4 cycles after accept; resp_ready held low 3 cycles → resp_valid/resp_data held, req_ready=0, no strobes.
- reset_n pulsed low during RD of SB addr 0x4 → MemRead drops immediately, no MemWrite ever; after release req_ready=1 and the word is unchanged.
- LW addr 0x6 → with MEM_ACCESS_ALIGN_CHECK_EN: resp_err=1 after 1 cycle, no strobes; without: reads word 1, resp_err=0.
